// File: rtl/wimpfi_pkg.sv
// Shared definitions for the wimpfi transmit path: byte width, frame type
// codes and the transmit arbiter state encoding.
package wimpfi_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] FT_DATA   = "1";
    localparam logic [BYTE_W-1:0] FT_ACKREQ = "2";
    localparam logic [BYTE_W-1:0] FT_ACK    = "3";

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_ACK  = 2'd1,
        GNT_HOST = 2'd2,
        COMMIT   = 2'd3
    } tx_arb_state_t;

endpackage

// File: rtl/tx_byte_mux.sv
// Source-select mux and output register feeding the transmitter FIFO write port.
module tx_byte_mux
    import wimpfi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sel_host,
    input  logic              accept,
    input  logic [BYTE_W-1:0] host_data,
    input  logic [BYTE_W-1:0] ack_data,
    output logic [BYTE_W-1:0] fifo_data,
    output logic              fifo_write
);

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_data  <= '0;
            fifo_write <= 1'b0;
        end else begin
            fifo_write <= accept;
            // data holds its last value between strobes
            if (accept) begin
                fifo_data <= sel_host ? host_data : ack_data;
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-atomic arbiter between the host frame source and the ACK generator
// for the transmitter FIFO. Optional host starvation guard: STARVE_GUARD_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no owner; arbitrate when the channel is idle
// GNT_ACK  | ACK generator owns the FIFO
// GNT_HOST | host frame source owns the FIFO
// COMMIT   | final byte being written; commit pulse follows
module tx_frame_arbiter
    import wimpfi_pkg::*;
#(
    parameter int MAX_FRAME  = 32,
    parameter int ACK_STREAK = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cardet,
    input  logic              fifo_full,
    input  logic              host_req,
    input  logic              ack_req,
    input  logic [BYTE_W-1:0] host_data,
    input  logic [BYTE_W-1:0] ack_data,
    input  logic              host_write,
    input  logic              ack_write,
    input  logic              host_last,
    input  logic              ack_last,
    output logic              host_gnt,
    output logic              ack_gnt,
    output logic [BYTE_W-1:0] fifo_data,
    output logic              fifo_write,
    output logic              fifo_commit,
    output logic              busy,
    output logic              err_overflow,
    output logic              err_length
);

    localparam logic [7:0] LIMIT_M1 = 8'(MAX_FRAME - 1);

    // Out-of-range parameters surface as this block in the elaborated hierarchy.
    if (MAX_FRAME < 4 || MAX_FRAME > 255 || ACK_STREAK < 1 || ACK_STREAK > 255) begin : g_param_out_of_range
    end

    tx_arb_state_t state, state_nxt;
    logic [7:0] byte_cnt;
    logic       granted;
    logic       cur_write;
    logic       cur_last;
    logic       accept;
    logic       drop;
    logic       frame_end;
    logic       host_turn;

    always_comb begin
        granted   = (state == GNT_ACK) || (state == GNT_HOST);
        cur_write = (state == GNT_HOST) ? host_write : ack_write;
        cur_last  = (state == GNT_HOST) ? host_last  : ack_last;
        accept    = granted && cur_write && !fifo_full;
        drop      = granted && cur_write && fifo_full;
        frame_end = accept && (cur_last || (byte_cnt == LIMIT_M1));
    end

`ifdef STARVE_GUARD_EN
    logic [7:0] streak;

    assign host_turn = host_req && (streak >= 8'(ACK_STREAK));

    // consecutive ACK grants made while the host was waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (state == IDLE && state_nxt == GNT_HOST) begin
            streak <= '0;
        end else if (state == IDLE && state_nxt == GNT_ACK) begin
            if (!host_req) begin
                streak <= '0;
            end else if (streak < 8'(ACK_STREAK)) begin
                streak <= streak + 8'd1;
            end
        end
    end
`else
    assign host_turn = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!cardet) begin
                    if (ack_req && !host_turn) begin
                        state_nxt = GNT_ACK;
                    end else if (host_req) begin
                        state_nxt = GNT_HOST;
                    end
                end
            end
            GNT_ACK, GNT_HOST: begin
                if (frame_end) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            fifo_commit  <= 1'b0;
            err_overflow <= 1'b0;
            err_length   <= 1'b0;
        end else begin
            state       <= state_nxt;
            fifo_commit <= (state == COMMIT);
            if (state == IDLE) begin
                byte_cnt <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 8'd1;
            end
            if (drop) begin
                err_overflow <= 1'b1;
            end
            if (frame_end && !cur_last) begin
                err_length <= 1'b1;
            end
        end
    end

    assign host_gnt = (state == GNT_HOST);
    assign ack_gnt  = (state == GNT_ACK);
    assign busy     = (state != IDLE);

    tx_byte_mux u_byte_mux (
        .clk        (clk),
        .reset      (reset),
        .sel_host   (state == GNT_HOST),
        .accept     (accept),
        .host_data  (host_data),
        .ack_data   (ack_data),
        .fifo_data  (fifo_data),
        .fifo_write (fifo_write)
    );

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: directed vector table, grant-order
// sequence for the starvation guard, and randomized traffic against a model.
module tb_tx_frame_arbiter;

    localparam int MF = 4;
    localparam int KS = 2;

    logic       clk = 1'b0;
    logic       reset, cardet, fifo_full;
    logic       host_req, ack_req, host_write, ack_write, host_last, ack_last;
    logic [7:0] host_data, ack_data;
    logic       host_gnt, ack_gnt, fifo_write, fifo_commit, busy, err_overflow, err_length;
    logic [7:0] fifo_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tx_frame_arbiter #(.MAX_FRAME(MF), .ACK_STREAK(KS)) dut (
        .clk(clk), .reset(reset), .cardet(cardet), .fifo_full(fifo_full),
        .host_req(host_req), .ack_req(ack_req),
        .host_data(host_data), .ack_data(ack_data),
        .host_write(host_write), .ack_write(ack_write),
        .host_last(host_last), .ack_last(ack_last),
        .host_gnt(host_gnt), .ack_gnt(ack_gnt),
        .fifo_data(fifo_data), .fifo_write(fifo_write), .fifo_commit(fifo_commit),
        .busy(busy), .err_overflow(err_overflow), .err_length(err_length)
    );

    typedef struct {
        logic rst, cd, ff, hreq, hw, hl, areq, aw, al;
        logic [7:0] hd, ad;
        logic hg, ag, fw, fc, bsy, eov, elen;
        logic [7:0] fd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, cd, ff, hreq, hw, hl, input logic [7:0] hd,
                                input logic areq, aw, al, input logic [7:0] ad,
                                input logic hg, ag, fw, input logic [7:0] fd,
                                input logic fc, bsy, eov, elen);
        vec_t v;
        v.rst = rst; v.cd = cd; v.ff = ff; v.hreq = hreq; v.hw = hw; v.hl = hl; v.hd = hd;
        v.areq = areq; v.aw = aw; v.al = al; v.ad = ad;
        v.hg = hg; v.ag = ag; v.fw = fw; v.fd = fd; v.fc = fc; v.bsy = bsy; v.eov = eov; v.elen = elen;
        vecs.push_back(v);
    endfunction

    // data is only meaningful while the write strobe is high
    function automatic logic [14:0] bundle(input logic hg, ag, fw, input logic [7:0] fd,
                                           input logic fc, bsy, eov, elen);
        return {hg, ag, fw, (fw ? fd : 8'h00), fc, bsy, eov, elen};
    endfunction

    function automatic logic [14:0] dut_bundle();
        return bundle(host_gnt, ack_gnt, fifo_write, fifo_data, fifo_commit, busy, err_overflow, err_length);
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h (hg ag fw fd fc busy eov elen)", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rst, cd, ff, hreq, hw, hl, input logic [7:0] hd,
                         input logic areq, aw, al, input logic [7:0] ad);
        reset = rst; cardet = cd; fifo_full = ff;
        host_req = hreq; host_write = hw; host_last = hl; host_data = hd;
        ack_req = areq; ack_write = aw; ack_last = al; ack_data = ad;
    endtask

    // Reference model: who owns the FIFO, how many bytes it has landed, and
    // how many cycles remain in the post-frame turnaround.
    int         m_owner;    // 0 none, 1 ack, 2 host
    int         m_bytes;
    int         m_turn;     // 2: final byte landing, 1: commit cycle, 0: free
    int         m_streak;
    logic       m_fw, m_fc, m_eov, m_elen;
    logic [7:0] m_fd;

    task automatic model_step();
        logic w, l;
        logic [7:0] d;
        if (reset) begin
            m_owner = 0; m_bytes = 0; m_turn = 0; m_streak = 0;
            m_fw = 0; m_fc = 0; m_eov = 0; m_elen = 0; m_fd = 8'h00;
            return;
        end
        m_fc = (m_turn == 2);
        m_fw = 1'b0;
        if (m_owner != 0) begin
            w = (m_owner == 2) ? host_write : ack_write;
            l = (m_owner == 2) ? host_last  : ack_last;
            d = (m_owner == 2) ? host_data  : ack_data;
            if (w && fifo_full) m_eov = 1'b1;
            else if (w) begin
                m_fw = 1'b1; m_fd = d; m_bytes++;
                if (l || m_bytes == MF) begin
                    if (!l) m_elen = 1'b1;
                    m_owner = 0; m_turn = 2;
                end
            end
        end else if (m_turn > 0) begin
            m_turn = (m_turn == 2) ? 1 : 0;
            if (m_turn == 1) m_turn = 0;
        end else if (!cardet) begin
            bit host_first;
`ifdef STARVE_GUARD_EN
            host_first = host_req && (m_streak >= KS);
`else
            host_first = 1'b0;
`endif
            if (ack_req && !host_first) begin
                m_owner = 1; m_bytes = 0;
                m_streak = host_req ? ((m_streak < KS) ? m_streak + 1 : m_streak) : 0;
            end else if (host_req) begin
                m_owner = 2; m_bytes = 0; m_streak = 0;
            end
        end
    endtask

    initial begin
        int order[$];
        int exp_order[6];
        int cyc;

        drive(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);

        //  rst cd ff hreq hw hl hd     areq aw al ad      hg ag fw fd     fc bsy eov elen
        add(1, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0, 0, 0, 0);
        // host-only frame
        add(0, 0, 0, 1, 0, 0, 8'h00,  0, 0, 0, 8'h00,   1, 0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8'h04,  0, 0, 0, 8'h00,   1, 0, 1, 8'h04, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, "1",    0, 0, 0, 8'h00,   1, 0, 1, "1",   0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8'h22,  0, 0, 0, 8'h00,   1, 0, 1, 8'h22, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1, 8'hA5,  0, 0, 0, 8'h00,   0, 0, 1, 8'hA5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0, 0, 0, 0);
        // fifo_full on the 2nd byte
        add(0, 0, 0, 1, 0, 0, 8'h00,  0, 0, 0, 8'h00,   1, 0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8'h04,  0, 0, 0, 8'h00,   1, 0, 1, 8'h04, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, "1",    0, 0, 0, 8'h00,   1, 0, 0, 8'h00, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 8'h22,  0, 0, 0, 8'h00,   1, 0, 1, 8'h22, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 8'hA5,  0, 0, 0, 8'h00,   0, 0, 1, 8'hA5, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 1, 0, 1, 0);
        // 6 bytes without host_last, limit 4
        add(0, 0, 0, 1, 0, 0, 8'h00,  0, 0, 0, 8'h00,   1, 0, 0, 8'h00, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 8'h01,  0, 0, 0, 8'h00,   1, 0, 1, 8'h01, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 8'h02,  0, 0, 0, 8'h00,   1, 0, 1, 8'h02, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 8'h03,  0, 0, 0, 8'h00,   1, 0, 1, 8'h03, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 8'h04,  0, 0, 0, 8'h00,   0, 0, 1, 8'h04, 0, 1, 1, 1);
        add(0, 0, 0, 0, 1, 0, 8'h05,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 1, 0, 1, 1);
        add(0, 0, 0, 0, 1, 0, 8'h06,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0, 0, 1, 1);
        // carrier busy holds off the ACK request
        for (int i = 0; i < 10; i++)
            add(0, 1, 0, 0, 0, 0, 8'h00,  1, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 8'h00,  1, 0, 0, 8'h00,   0, 1, 0, 8'h00, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 1, 0, 8'h04,   0, 1, 1, 8'h04, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 1, 0, "3",     0, 1, 1, "3",   0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 1, 1, 8'h22,   0, 0, 1, 8'h22, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 1, 0, 1, 1);
        // simultaneous requests: ACK first, host writes ignored, host 3 cycles after ACK last
        add(0, 0, 0, 1, 0, 0, 8'h00,  1, 0, 0, 8'h00,   0, 1, 0, 8'h00, 0, 1, 1, 1);
        add(0, 0, 0, 1, 1, 1, 8'hFF,  0, 1, 0, 8'h04,   0, 1, 1, 8'h04, 0, 1, 1, 1);
        add(0, 0, 0, 1, 1, 0, 8'hFF,  0, 1, 0, "3",     0, 1, 1, "3",   0, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0, 8'h00,  0, 1, 1, 8'h22,   0, 0, 1, 8'h22, 0, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 1, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 8'h00,  0, 0, 0, 8'h00,   1, 0, 0, 8'h00, 0, 1, 1, 1);
        add(0, 0, 0, 0, 1, 1, 8'hAA,  0, 0, 0, 8'h00,   0, 0, 1, 8'hAA, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0, 0, 1, 1);
        // reset mid-frame clears everything, no commit
        add(0, 0, 0, 1, 0, 0, 8'h00,  0, 0, 0, 8'h00,   1, 0, 0, 8'h00, 0, 1, 1, 1);
        add(0, 0, 0, 0, 1, 0, 8'h11,  0, 0, 0, 8'h00,   1, 0, 1, 8'h11, 0, 1, 1, 1);
        add(1, 0, 0, 0, 1, 0, 8'h12,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0, 0, 0, 0);
        // request dropped before grant
        add(0, 1, 0, 1, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].cd, vecs[i].ff, vecs[i].hreq, vecs[i].hw, vecs[i].hl, vecs[i].hd,
                  vecs[i].areq, vecs[i].aw, vecs[i].al, vecs[i].ad);
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), dut_bundle(),
                bundle(vecs[i].hg, vecs[i].ag, vecs[i].fw, vecs[i].fd, vecs[i].fc, vecs[i].bsy, vecs[i].eov, vecs[i].elen));
            if (i == 0) chk("reset_fifo_data", {7'd0, fifo_data}, 15'd0);
        end

        // both requests held high, one-byte frames: record grant order
        drive(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        @(posedge clk); #1;
        cyc = 0;
        drive(0, 0, 0, 1, 0, 1, 8'h5A, 1, 0, 1, 8'hC3);
        while (order.size() < 6 && cyc < 200) begin
            host_write = host_gnt;
            ack_write  = ack_gnt;
            @(posedge clk); #1;
            cyc++;
            if (host_gnt) order.push_back(2);
            else if (ack_gnt) order.push_back(1);
        end
`ifdef STARVE_GUARD_EN
        exp_order = '{1, 1, 2, 1, 1, 2};
`else
        exp_order = '{1, 1, 1, 1, 1, 1};
`endif
        if (order.size() < 6) begin
            n_tests++; n_fail++;
            $display("FAIL streak_timeout: got %0d grants, required 6", order.size());
        end else begin
            for (int i = 0; i < 6; i++)
                chk($sformatf("grant_order%0d", i), 15'(order[i]), 15'(exp_order[i]));
        end

        // randomized traffic against the model
        drive(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        model_step();
        @(posedge clk); #1;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  8'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  8'($urandom));
            model_step();
            @(posedge clk); #1;
            chk($sformatf("rand%0d", c), dut_bundle(),
                bundle(m_owner == 2, m_owner == 1, m_fw, m_fd, m_fc, (m_owner != 0) || (m_turn == 2),
                       m_eov, m_elen));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Arbitrates byte-wide writes into the shared transmitter FIFO between the host frame source (type 1/2 frames from the UART path) and the ACK generator (type 3 frames). Grants are frame-atomic: once a source owns the FIFO, it keeps it until its last byte, and no bytes from the two sources interleave. ACK frames have priority. A new frame is only granted while the channel is idle (`cardet` low). The block sits between both frame sources and the transmitter FIFO write port.

## Interface
- `MAX_FRAME`, 32: maximum bytes per frame, including header bytes; range 4..255.
- `ACK_STREAK`, 2: consecutive ACK grants allowed while the host waits (used only with `STARVE_GUARD_EN`).

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `cardet`  in  1  carrier detect; high = channel busy
- `fifo_full`  in  1  transmitter FIFO full
- `host_req`, `ack_req`  in  1  source has a frame pending; level, held until granted
- `host_data`, `ack_data`  in  8  frame byte
- `host_write`, `ack_write`  in  1  byte valid
- `host_last`, `ack_last`  in  1  qualifies write: final byte of frame
- `host_gnt`, `ack_gnt`  out  1  source owns the FIFO
- `fifo_data`  out  8  byte to FIFO
- `fifo_write`  out  1  FIFO write strobe
- `fifo_commit`  out  1  one-cycle pulse: frame complete, transmitter may start
- `busy`  out  1  state ≠ IDLE
- `err_overflow`  out  1  sticky: write dropped because `fifo_full` was high
- `err_length`  out  1  sticky: frame force-terminated at `MAX_FRAME`

## Operation
- FSM states: IDLE, GNT_ACK, GNT_HOST, COMMIT.
- IDLE, `cardet`=0:
  - `ack_req` → GNT_ACK.
  - Otherwise `host_req` → GNT_HOST.
  - With `cardet`=1: stay in IDLE.
- GNT_x:
  - `x_gnt`=1.
  - A byte is accepted when `x_write` & !`fifo_full`. Accepted bytes are registered to `fifo_data`/`fifo_write`.
  - Inputs from the non-granted source are ignored.
  - `cardet` is ignored mid-frame.
- Write with `fifo_full`=1: byte dropped, `err_overflow` set. The frame continues.
- Accepted byte with `x_last`, or the accepted byte that makes the count reach `MAX_FRAME` → COMMIT.
  - The count-limit case without `x_last` also sets `err_length`.
- COMMIT: `x_gnt`=0 and the final byte is written. The next cycle pulses `fifo_commit` and returns to IDLE.
- Byte counter: 8-bit, cleared on entry to GNT_x, incremented per accepted byte. It never wraps, because it is bounded by `MAX_FRAME`.
- `host_req` and `ack_req` both high in IDLE → ACK wins.
- `host_req` rising while an ACK frame is granted: the host frame is queued and granted on the next IDLE with `cardet`=0.
- A request dropped before grant is ignored. A grant is never issued to a source whose request is low.
- Sticky error flags clear only on `reset`.
- Reset mid-frame: state → IDLE. The partial frame is not committed; the FIFO owner flushes on `reset`.

## Timing
- Reset values: `host_gnt`=`ack_gnt`=`fifo_write`=`fifo_commit`=`busy`=`err_*`=0, `fifo_data`=8'h00.
- Request sampled at cycle n with `cardet`=0 → grant high at n+1.
- Byte accepted at cycle m → `fifo_write`/`fifo_data` valid at m+1, one-cycle strobe.
- Last byte accepted at m:
  - m+1: grant low, last-byte write.
  - m+2: `fifo_commit`=1.
  - m+3: earliest next grant. Turnaround from frame to frame is 2 idle cycles minimum.
- Back-to-back accepted bytes are supported at full rate, one per cycle.

## Configuration
- `STARVE_GUARD_EN` defined:
  - Counts consecutive ACK grants made while `host_req` is high.
  - When the count reaches `ACK_STREAK`, the next IDLE arbitration grants the host even if `ack_req` is high.
  - The count clears on any host grant.
- Undefined: strict ACK priority. The host can starve indefinitely.

## Structure
- Shared package `wimpfi_pkg`:
  - state enum `tx_arb_state_t`
  - frame type constants `FT_DATA`="1", `FT_ACKREQ`="2", `FT_ACK`="3"
  - `BYTE_W`=8
- One sub-module, `tx_byte_mux`: source-select mux plus output register. The select comes from the FSM, and the mux produces `fifo_data`/`fifo_write`. All other logic stays in the top level.

## Test plan
- Host-only frame: host sends {8'h04,"1",8'h22,8'hA5} with `cardet`=0.
  - `host_gnt` rises 1 cycle after `host_req`.
  - 4 `fifo_write` pulses with bytes in order.
  - `fifo_commit` 2 cycles after the last byte is accepted.
- Simultaneous `host_req`/`ack_req`:
  - The ACK frame {8'h04,"3",8'h22} is written and committed first.
  - The host frame is granted 3 cycles after the ACK last byte.
- `cardet`=1 held for 10 cycles with `ack_req` high: no grant. Grant follows 1 cycle after `cardet` falls.
- `fifo_full` pulsed on the 2nd of 4 host writes: that byte is dropped, `err_overflow`=1, 3 writes plus commit occur.
- `MAX_FRAME`=4, host sends 6 bytes without `host_last`:
  - Commit after byte 4, `err_length`=1.
  - Bytes 5–6 are not written.
- `STARVE_GUARD_EN`, `ACK_STREAK`=2, both requests constantly high:
  - Grant order ACK, ACK, HOST, ACK, ACK, HOST.
  - Without the macro: ACK only.
